// File: rtl/segment_address_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | segment_address_unit: segment select + 16-bit offset -> 20-bit physical  |
// | address via (seg << 4) + offset.  Override prefix: S80X86_SEG_OVERRIDE_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module segment_address_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  default_seg,
  input  logic        allow_override,
  input  logic [15:0] offset,
  input  logic        override_set,
  input  logic [1:0]  override_sel,
  input  logic        override_clear,
  output logic [1:0]  rd_sel,
  input  logic [15:0] rd_val,
  output logic        busy,
  output logic        done,
  output logic [19:0] phys_addr,
  output logic [1:0]  seg_used
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  seg_q, seg_d;
  logic [15:0] offset_q, offset_d;
  logic [19:0] phys_addr_q, phys_addr_d;
  logic [1:0]  seg_used_q, seg_used_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  eff_seg;
  logic        accept;

`ifdef S80X86_SEG_OVERRIDE_EN
  logic       ovr_active_q, ovr_active_d;
  logic [1:0] ovr_seg_q, ovr_seg_d;

  always_comb begin
    ovr_active_d = ovr_active_q;
    ovr_seg_d    = ovr_seg_q;
    if (override_set) begin
      ovr_active_d = 1'b1;
      ovr_seg_d    = override_sel;
    end else if (override_clear) begin
      ovr_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_active_q <= 1'b0;
      ovr_seg_q    <= 2'd0;
    end else begin
      ovr_active_q <= ovr_active_d;
      ovr_seg_q    <= ovr_seg_d;
    end
  end

  // Requests see the override state from before any same-cycle update.
  assign eff_seg = (ovr_active_q && allow_override) ? ovr_seg_q : default_seg;
`else
  logic unused_override;
  assign unused_override = ^{override_set, override_clear, override_sel, allow_override};
  assign eff_seg = default_seg;
`endif

  assign accept = start && (state_q != ST_ADD);
  assign rd_sel = accept ? eff_seg : seg_q;

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    offset_d    = offset_q;
    phys_addr_d = phys_addr_q;
    seg_used_d  = seg_used_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ADD;
      ST_ADD: begin
        state_d     = ST_DONE;
        phys_addr_d = {rd_val, 4'b0000} + {4'b0000, offset_q};
        seg_used_d  = seg_q;
      end
      ST_DONE: state_d = start ? ST_ADD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      seg_d    = eff_seg;
      offset_d = offset;
    end
    busy_d = (state_d == ST_ADD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      seg_q       <= 2'd0;
      offset_q    <= 16'd0;
      phys_addr_q <= 20'd0;
      seg_used_q  <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      offset_q    <= offset_d;
      phys_addr_q <= phys_addr_d;
      seg_used_q  <= seg_used_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign phys_addr = phys_addr_q;
  assign seg_used  = seg_used_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_address_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_segment_address_unit: scoreboard bench with a segment register file   |
// | model (registered read, write bypass).  Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module tb_segment_address_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  default_seg;
  logic        allow_override;
  logic [15:0] offset;
  logic        override_set;
  logic [1:0]  override_sel;
  logic        override_clear;
  logic [1:0]  rd_sel;
  logic [15:0] rd_val;
  logic        busy;
  logic        done;
  logic [19:0] phys_addr;
  logic [1:0]  seg_used;

  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [15:0] wr_data;
  logic [15:0] segs [4];

  logic        m_act;
  logic [1:0]  m_seg;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [19:0] addr;
    logic [1:0]  seg;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  segment_address_unit dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .default_seg    (default_seg),
    .allow_override (allow_override),
    .offset         (offset),
    .override_set   (override_set),
    .override_sel   (override_sel),
    .override_clear (override_clear),
    .rd_sel         (rd_sel),
    .rd_val         (rd_val),
    .busy           (busy),
    .done           (done),
    .phys_addr      (phys_addr),
    .seg_used       (seg_used)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: registered read with same-cycle write bypass.
  always @(posedge clk) begin
    if (wr_en) segs[wr_sel] <= wr_data;
    rd_val <= (wr_en && wr_sel == rd_sel) ? wr_data : segs[rd_sel];
  end

  // Reference override state.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act <= 1'b0;
      m_seg <= 2'd0;
    end else if (override_set) begin
      m_act <= 1'b1;
      m_seg <= override_sel;
    end else if (override_clear) begin
      m_act <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("phys_addr", 32'(phys_addr), 32'(e.addr));
        check("seg_used", 32'(seg_used), 32'(e.seg));
        check("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
  end

  function automatic logic [1:0] eff_of(input logic [1:0] s, input logic a);
`ifdef S80X86_SEG_OVERRIDE_EN
    return (m_act && a) ? m_seg : s;
`else
    return (a && 1'b0) ? m_seg : s;
`endif
  endfunction

  // Called at a negedge: raise start and record the expected result.
  task automatic issue(input logic [1:0] s, input logic a, input logic [15:0] off);
    exp_t e;
    logic [1:0]  eff;
    logic [15:0] sv;
    start = 1'b1;
    default_seg = s;
    allow_override = a;
    offset = off;
    eff = eff_of(s, a);
    sv = (wr_en && wr_sel == eff) ? wr_data : segs[eff];
    e.addr = {sv, 4'b0000} + {4'b0000, off};
    e.seg = eff;
    e.cyc = cyc;
    sb.push_back(e);
    #1 check("rd_sel", 32'(rd_sel), 32'(eff));
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic single(input logic [1:0] s, input logic a, input logic [15:0] off);
    @(negedge clk);
    issue(s, a, off);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  task automatic set_seg(input logic [1:0] sel, input logic [15:0] val);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_data = val;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic ovr(input logic s, input logic c, input logic [1:0] sel);
    @(negedge clk);
    override_set = s; override_clear = c; override_sel = sel;
    @(negedge clk);
    override_set = 1'b0; override_clear = 1'b0;
  endtask

  initial begin
    logic [1:0] ovr_exp;
`ifdef S80X86_SEG_OVERRIDE_EN
    ovr_exp = 2'd2;
`else
    ovr_exp = 2'd3;
`endif
    reset = 1'b1; start = 1'b0; default_seg = 2'd0; allow_override = 1'b0;
    offset = 16'd0; override_set = 1'b0; override_sel = 2'd0; override_clear = 1'b0;
    wr_en = 1'b0; wr_sel = 2'd0; wr_data = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_phys", 32'(phys_addr), 32'd0);
    check("rst_seg_used", 32'(seg_used), 32'd0);
    check("rst_rd_sel", 32'(rd_sel), 32'd0);
    reset = 1'b0;

    set_seg(2'd0, 16'hFFFF);
    set_seg(2'd1, 16'h1000);
    set_seg(2'd2, 16'h2000);
    set_seg(2'd3, 16'h1234);

    single(2'd3, 1'b0, 16'h0010);
    check("basic_lit", 32'(phys_addr), 32'h12350);
    single(2'd0, 1'b0, 16'h0010);
    check("wrap0_lit", 32'(phys_addr), 32'h00000);
    single(2'd0, 1'b0, 16'hFFFF);
    check("wrap1_lit", 32'(phys_addr), 32'h0FFEF);

    ovr(1'b1, 1'b0, 2'd2);
    single(2'd3, 1'b1, 16'h0010);
    check("ovr_lit", 32'(seg_used), 32'(ovr_exp));
    single(2'd3, 1'b0, 16'h0010);
    check("ovr_noallow_lit", 32'(seg_used), 32'd3);
    ovr(1'b0, 1'b1, 2'd0);
    single(2'd3, 1'b1, 16'h0010);
    check("ovr_cleared_lit", 32'(seg_used), 32'd3);

    ovr(1'b1, 1'b1, 2'd1);
    single(2'd3, 1'b1, 16'h0020);
    ovr(1'b0, 1'b1, 2'd0);

    // Override set in the accept cycle must not affect that request.
    @(negedge clk);
    override_set = 1'b1; override_sel = 2'd2;
    issue(2'd3, 1'b1, 16'h0030);
    @(negedge clk);
    override_set = 1'b0; start = 1'b0;
    drain();
    check("ovr_pre_update_lit", 32'(seg_used), 32'd3);
    single(2'd3, 1'b1, 16'h0031);
    ovr(1'b0, 1'b1, 2'd0);

    // Back-to-back: second start in the DONE cycle.
    @(negedge clk);
    issue(2'd1, 1'b0, 16'h0005);
    @(negedge clk);
    start = 1'b0;
    check("busy_in_add", 32'(busy), 32'd1);
    @(negedge clk);
    issue(2'd2, 1'b0, 16'h0007);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start while busy is ignored.
    @(negedge clk);
    issue(2'd3, 1'b0, 16'h0001);
    @(negedge clk);
    start = 1'b1; default_seg = 2'd0; offset = 16'h0099;
    #1 check("ignored_rd_sel", 32'(rd_sel), 32'd3);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Reset in the ADD cycle drops the request.
    @(negedge clk);
    issue(2'd3, 1'b0, 16'h0040);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    sb.delete();
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_phys", 32'(phys_addr), 32'd0);
    check("midrst_rd_sel", 32'(rd_sel), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_phys_after", 32'(phys_addr), 32'd0);
    single(2'd3, 1'b0, 16'h0040);
    check("post_rst_lit", 32'(phys_addr), 32'h12380);

    // Register write in the accept cycle is bypassed to the read.
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 2'd3; wr_data = 16'h5678;
    issue(2'd3, 1'b0, 16'h0002);
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    drain();
    check("bypass_lit", 32'(phys_addr), 32'h56782);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
